// File: rtl/matrix_result_streamer.sv
// Captures the controller's flattened product matrix on the rising edge of done and streams it out
// row-major over valid/ready. Define MATRIX_STREAMER_ROW_LAST_EN to add the out_row_last output.
module matrix_result_streamer #(
  parameter int MATRIX_SIZE = 16,
  parameter int DATA_SIZE   = 8
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         done,
  input  logic [DATA_SIZE*MATRIX_SIZE*MATRIX_SIZE-1:0] in_matrix,
  output logic [DATA_SIZE-1:0]                         out_data,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic                                         out_last,
`ifdef MATRIX_STREAMER_ROW_LAST_EN
  output logic                                         out_row_last,
`endif
  output logic                                         busy,
  output logic                                         overrun
);

  localparam int NUM_ELEMS = MATRIX_SIZE * MATRIX_SIZE;
  localparam int IDX_W = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     idx_reg, idx_next, idx_inc;
  logic [DATA_SIZE-1:0] data_reg, data_next;
  logic                 valid_reg, valid_next;
  logic                 last_reg, last_next;
  logic                 overrun_reg, overrun_next;
  logic                 done_q_reg;
  logic                 done_edge, transfer, capture;

  logic [DATA_SIZE-1:0] in_elem    [NUM_ELEMS];
  logic [DATA_SIZE-1:0] buffer_mem [NUM_ELEMS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ELEMS; gi++) begin : g_unpack
      assign in_elem[gi] = in_matrix[gi*DATA_SIZE +: DATA_SIZE];
    end
  endgenerate

  assign done_edge = done & ~done_q_reg;
  assign transfer  = valid_reg & out_ready;
  assign idx_inc   = idx_reg + 1'b1;

  // Snapshot storage; contents are don't-care until the first capture.
  always_ff @(posedge clk) begin
    if (capture) buffer_mem <= in_elem;
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    data_next    = data_reg;
    valid_next   = valid_reg;
    overrun_next = overrun_reg;
    capture      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (done_edge) begin
          capture    = 1'b1;
          idx_next   = '0;
          data_next  = in_elem[0];
          valid_next = 1'b1;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (transfer && idx_reg == LAST_IDX) begin
          // A new result landing exactly on the final beat chains straight on with no gap.
          idx_next = '0;
          if (done_edge) begin
            capture   = 1'b1;
            data_next = in_elem[0];
          end else begin
            valid_next = 1'b0;
            state_next = IDLE;
          end
        end else begin
          if (transfer) begin
            idx_next  = idx_inc;
            data_next = buffer_mem[idx_inc];
          end
          if (done_edge) overrun_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign last_next = valid_next && (idx_next == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      last_reg    <= 1'b0;
      overrun_reg <= 1'b0;
      done_q_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      last_reg    <= last_next;
      overrun_reg <= overrun_next;
      done_q_reg  <= done;
    end
  end

`ifdef MATRIX_STREAMER_ROW_LAST_EN
  logic row_last_reg, row_last_next;

  assign row_last_next = valid_next && ((int'(idx_next) % MATRIX_SIZE) == MATRIX_SIZE - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) row_last_reg <= 1'b0;
    else        row_last_reg <= row_last_next;
  end

  assign out_row_last = row_last_reg;
`endif

  assign out_data  = data_reg;
  assign out_valid = valid_reg;
  assign out_last  = last_reg;
  assign busy      = (state_reg == STREAM);
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Scoreboard bench for matrix_result_streamer: stimulus pushes expected beats, a negedge monitor
// pops and compares every accepted beat and checks stall stability.
module tb_matrix_result_streamer;
  localparam int MS = 16;
  localparam int DS = 8;
  localparam int N  = MS * MS;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            done = 1'b0;
  logic            out_ready = 1'b0;
  logic [DS*N-1:0] in_matrix = '0;
  logic [DS-1:0]   out_data;
  logic            out_valid, out_last, busy, overrun;
`ifdef MATRIX_STREAMER_ROW_LAST_EN
  logic            out_row_last;
`endif

  always #5 clk = ~clk;

  matrix_result_streamer #(.MATRIX_SIZE(MS), .DATA_SIZE(DS)) dut (
    .clk       (clk),
    .reset     (reset),
    .done      (done),
    .in_matrix (in_matrix),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
`ifdef MATRIX_STREAMER_ROW_LAST_EN
    .out_row_last(out_row_last),
`endif
    .busy      (busy),
    .overrun   (overrun)
  );

  typedef struct packed {
    logic [DS-1:0] data;
    logic          last;
    logic          row_last;
  } beat_t;

  beat_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int row_pulses = 0;
  int beat_no = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one line per accepted beat, compared against the scoreboard head.
  initial begin
    logic          prev_stall;
    logic [DS-1:0] prev_data;
    beat_t         e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", 32'(out_data), 32'(prev_data));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_beat: got data %0h expected no beat (t=%0t)", out_data, $time);
          end else begin
            e = sb.pop_front();
            $display("beat %0d: data=%0h last=%0b exp data=%0h last=%0b", beat_no, out_data, out_last, e.data, e.last);
            beat_no++;
            check("beat_data", 32'(out_data), 32'(e.data));
            check("beat_last", 32'(out_last), 32'(e.last));
`ifdef MATRIX_STREAMER_ROW_LAST_EN
            check("beat_row_last", 32'(out_row_last), 32'(e.row_last));
            if (out_row_last) row_pulses++;
`endif
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_matrix(input bit rev);
    for (int i = 0; i < N; i++) in_matrix[i*DS +: DS] = rev ? DS'(N - 1 - i) : DS'(i);
  endtask

  task automatic push_stream(input bit rev);
    beat_t e;
    for (int i = 0; i < N; i++) begin
      e.data     = rev ? DS'(N - 1 - i) : DS'(i);
      e.last     = (i == N - 1);
      e.row_last = ((i % MS) == MS - 1);
      sb.push_back(e);
    end
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  // Runs until the scoreboard empties, then one more edge so the final transfer has happened.
  task automatic wait_drain(input bit alt, input int limit);
    int k;
    k = 0;
    while (sb.size() != 0 && k < limit) begin
      if (alt) out_ready = ~out_ready;
      tick();
      k++;
    end
    check("drain_left", 32'(sb.size()), 32'd0);
    tick();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_last"}, 32'(out_last), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    set_matrix(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    check("reset_data", 32'(out_data), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
`ifdef MATRIX_STREAMER_ROW_LAST_EN
    check("reset_row_last", 32'(out_row_last), 32'd0);
`endif
    reset = 1'b1;
    tick();

    // 1: basic stream, ready always high
    out_ready = 1'b1;
    push_stream(1'b0);
    check("t1_pre_valid", 32'(out_valid), 32'd0);
    pulse_done();
    check("t1_latency_valid", 32'(out_valid), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    wait_drain(1'b0, 400);
    check_idle("t1_end");
`ifdef MATRIX_STREAMER_ROW_LAST_EN
    check("t1_row_pulses", 32'(row_pulses), 32'd16);
`endif

    // 2: alternating ready
    push_stream(1'b0);
    pulse_done();
    wait_drain(1'b1, 1000);
    check_idle("t2_end");
    out_ready = 1'b1;

    // 3: snapshot isolation
    push_stream(1'b0);
    pulse_done();
    in_matrix = '1;
    wait_drain(1'b0, 400);
    check_idle("t3_end");
    set_matrix(1'b0);

    // 4: dropped capture at beat 10, then done held high
    push_stream(1'b0);
    pulse_done();
    repeat (10) tick();
    pulse_done();
    check("t4_overrun_set", 32'(overrun), 32'd1);
    wait_drain(1'b0, 400);
    check("t4_overrun_sticky", 32'(overrun), 32'd1);
    push_stream(1'b0);
    done = 1'b1;
    repeat (300) tick();
    done = 1'b0;
    tick();
    check("t4_held_left", 32'(sb.size()), 32'd0);
    check_idle("t4_held");
    check("t4_overrun_still", 32'(overrun), 32'd1);
    reset = 1'b0;
    #1;
    check("t4_reset_overrun", 32'(overrun), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // 5: new capture coincident with final transfer
    push_stream(1'b0);
    pulse_done();
    repeat (255) tick();
    set_matrix(1'b1);
    push_stream(1'b1);
    pulse_done();
    check("t5_valid_nogap", 32'(out_valid), 32'd1);
    check("t5_busy", 32'(busy), 32'd1);
    check("t5_data", 32'(out_data), 32'd255);
    check("t5_overrun", 32'(overrun), 32'd0);
    wait_drain(1'b0, 400);
    check_idle("t5_end");
    check("t5_overrun_end", 32'(overrun), 32'd0);

    // 5b: reset at beat 100 abandons the stream
    set_matrix(1'b0);
    push_stream(1'b0);
    pulse_done();
    repeat (50) tick();
    pulse_done();
    check("t5b_overrun_pre", 32'(overrun), 32'd1);
    repeat (49) tick();
    reset = 1'b0;
    #1;
    check("t5b_rst_valid", 32'(out_valid), 32'd0);
    check("t5b_rst_busy", 32'(busy), 32'd0);
    check("t5b_rst_overrun", 32'(overrun), 32'd0);
    sb.delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
    push_stream(1'b0);
    pulse_done();
    check("t5b_restart_data", 32'(out_data), 32'd0);
    wait_drain(1'b0, 400);
    check_idle("t5b_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
